// File: rtl/reflet_spi_pkg.sv
// rtl/reflet_spi_pkg.sv - shared constants and FSM state type for the SPI master
package reflet_spi_pkg;

    localparam logic [1:0] SPI_DATA = 2'd0;
    localparam logic [1:0] SPI_CTRL = 2'd1;
    localparam logic [1:0] SPI_DIV  = 2'd2;

    localparam int BUSY = 0;
    localparam int DONE = 1;
    localparam int OVR  = 2;
    localparam int CS   = 3;
    localparam int IE   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        TRAIL = 2'd2
    } spi_state_t;

endpackage

// File: rtl/reflet_spi_shifter.sv
// rtl/reflet_spi_shifter.sv - mode 0 SPI bit engine: FSM, clock divider, shift registers, miso sync
module reflet_spi_shifter
    import reflet_spi_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic [7:0] clkdiv,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       busy,
    output logic       done_set,
    output logic [7:0] rx_data
);

    spi_state_t state, state_next;
    logic [7:0] shift;
    logic [7:0] rx_shift;
    logic [7:0] divcnt;
    logic [2:0] bitcnt;
    logic       miso_s1, miso_s2;
    logic       div_hit;

    assign div_hit = (divcnt == clkdiv);
    // The last bit is never shifted out, so shift[7] keeps driving it once idle.
    assign mosi = shift[7];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = LEAD;
            LEAD:    if (div_hit) state_next = TRAIL;
            TRAIL:   if (div_hit) state_next = (bitcnt == 3'd7) ? IDLE : LEAD;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sclk     = (state == TRAIL);
        busy     = (state != IDLE);
        done_set = (state == TRAIL) && div_hit && (bitcnt == 3'd7);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift    <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            divcnt   <= '0;
            bitcnt   <= '0;
            miso_s1  <= 1'b0;
            miso_s2  <= 1'b0;
        end else begin
            miso_s1 <= miso;
            miso_s2 <= miso_s1;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        shift  <= tx_byte;
                        bitcnt <= '0;
                        divcnt <= '0;
                    end
                end
                LEAD: begin
                    if (div_hit) begin
                        divcnt   <= '0;
                        rx_shift <= {rx_shift[6:0], miso_s2};
                    end else begin
                        divcnt <= divcnt + 8'd1;
                    end
                end
                TRAIL: begin
                    if (div_hit) begin
                        divcnt <= '0;
                        if (bitcnt == 3'd7) begin
                            rx_data <= rx_shift;
                        end else begin
                            shift  <= {shift[6:0], 1'b0};
                            bitcnt <= bitcnt + 3'd1;
                        end
                    end else begin
                        divcnt <= divcnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/reflet_spi_master.sv
// rtl/reflet_spi_master.sv - memory-mapped SPI master: decode, registers, read mux
// Optional irq output and CTRL.ie bit are enabled by defining REFLET_SPI_INTERRUPT_EN.
module reflet_spi_master
    import reflet_spi_pkg::*;
#(
    parameter int wordsize       = 8,
    parameter int base_addr_size = 8,
    parameter logic [base_addr_size-1:0] base_addr = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [base_addr_size-1:0] addr,
    input  logic [wordsize-1:0]       data_in,
    output logic [wordsize-1:0]       data_out,
    input  logic                      write_en,
    output logic                      sclk,
    output logic                      mosi,
    input  logic                      miso,
    output logic                      cs_n
`ifdef REFLET_SPI_INTERRUPT_EN
    ,
    output logic                      irq
`endif
);

    logic       sel, wr;
    logic [1:0] offset;
    logic       busy, done_set;
    logic [7:0] rx_data;
    logic [7:0] clkdiv;
    logic       done, ovr, cs, ie;
    logic       data_wr, ctrl_wr;
    logic [7:0] status;

    assign sel     = enable && (addr[base_addr_size-1:2] == base_addr[base_addr_size-1:2]);
    assign offset  = addr[1:0];
    assign wr      = sel && write_en;
    assign data_wr = wr && (offset == SPI_DATA);
    assign ctrl_wr = wr && (offset == SPI_CTRL);
    assign cs_n    = ~cs;

    reflet_spi_shifter u_shifter (
        .clk      (clk),
        .reset    (reset),
        .start    (data_wr && !busy),
        .tx_byte  (data_in[7:0]),
        .clkdiv   (clkdiv),
        .miso     (miso),
        .sclk     (sclk),
        .mosi     (mosi),
        .busy     (busy),
        .done_set (done_set),
        .rx_data  (rx_data)
    );

    // A completing transfer takes priority over a simultaneous write-1-clear of done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done   <= 1'b0;
            ovr    <= 1'b0;
            cs     <= 1'b0;
            clkdiv <= '0;
        end else begin
            if (done_set) begin
                done <= 1'b1;
            end else if (ctrl_wr && data_in[DONE]) begin
                done <= 1'b0;
            end
            if (data_wr && busy) begin
                ovr <= 1'b1;
            end else if (ctrl_wr && data_in[OVR]) begin
                ovr <= 1'b0;
            end
            if (ctrl_wr) begin
                cs <= data_in[CS];
            end
            if (wr && (offset == SPI_DIV)) begin
                clkdiv <= data_in[7:0];
            end
        end
    end

`ifdef REFLET_SPI_INTERRUPT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ie <= 1'b0;
        end else if (ctrl_wr) begin
            ie <= data_in[IE];
        end
    end
    assign irq = done & ie;
`else
    assign ie = 1'b0;
`endif

    always_comb begin
        status       = '0;
        status[BUSY] = busy;
        status[DONE] = done;
        status[OVR]  = ovr;
        status[CS]   = cs;
        status[IE]   = ie;
        data_out     = '0;
        if (sel) begin
            unique case (offset)
                SPI_DATA: data_out[7:0] = rx_data;
                SPI_CTRL: data_out[7:0] = status;
                SPI_DIV:  data_out[7:0] = clkdiv;
                default:  data_out      = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_reflet_spi_master.sv
// tb/tb_reflet_spi_master.sv - randomized loopback bench for reflet_spi_master
module tb_reflet_spi_master;

    localparam logic [1:0] O_DATA = 2'd0;
    localparam logic [1:0] O_CTRL = 2'd1;
    localparam logic [1:0] O_DIV  = 2'd2;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       write_en;
    logic       sclk, mosi, miso, cs_n;
`ifdef REFLET_SPI_INTERRUPT_EN
    logic       irq;
`endif

    int checks = 0;
    int errors = 0;

    assign miso = mosi;

    always #5 clk = ~clk;

    reflet_spi_master dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .write_en (write_en),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso),
        .cs_n     (cs_n)
`ifdef REFLET_SPI_INTERRUPT_EN
        ,
        .irq      (irq)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [1:0] off, input logic [7:0] val);
        enable   = 1'b1;
        addr     = {6'd0, off};
        data_in  = val;
        write_en = 1'b1;
        @(posedge clk);
        #1;
        enable   = 1'b0;
        write_en = 1'b0;
    endtask

    task automatic rd(input logic [1:0] off, output logic [7:0] val);
        enable   = 1'b1;
        write_en = 1'b0;
        addr     = {6'd0, off};
        #1;
        val    = data_out;
        enable = 1'b0;
    endtask

    // inj: 0 none, 1 DATA write mid-transfer, 2 DATA write on the completing edge,
    // 3 done write-1-clear on the completing edge
    task automatic xfer(input logic [7:0] tx, input int d, input int inj,
                        input logic [7:0] ctrl_w, output logic [7:0] st);
        int len, k, n;
        logic [7:0] s;
        len = 16 * (d + 1);
        k   = (inj == 1) ? int'($urandom_range(1, len / 2)) : len - 1;
        wr(O_DATA, tx);
        rd(O_CTRL, s);
        check("busy after start", 32'(s[0]), 32'd1);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
            enable   = 1'b1;
            write_en = 1'b0;
            addr     = {6'd0, O_CTRL};
            #1;
            s      = data_out;
            enable = 1'b0;
            if (inj != 0 && n == k && s[0]) begin
                enable   = 1'b1;
                write_en = 1'b1;
                if (inj == 3) begin
                    addr    = {6'd0, O_CTRL};
                    data_in = ctrl_w | 8'h02;
                end else begin
                    addr    = {6'd0, O_DATA};
                    data_in = 8'($urandom);
                end
            end
        end while (s[0] && n < len + 100);
        enable   = 1'b0;
        write_en = 1'b0;
        check("latency", 32'(n), 32'(len));
        st = s;
    endtask

    task automatic wave(input int d, input logic [7:0] tx);
        int rises, last_rise, last_fall;
        logic prev_s, prev_m;
        logic [7:0] bits;
        wr(O_DIV, 8'(d));
        wr(O_DATA, tx);
        check("wave first mosi", 32'(mosi), 32'(tx[7]));
        prev_s    = sclk;
        prev_m    = mosi;
        rises     = 0;
        last_rise = 0;
        last_fall = 0;
        bits      = '0;
        for (int i = 1; i <= 16 * (d + 1) + 4; i++) begin
            @(posedge clk);
            #1;
            if (!prev_s && sclk) begin
                check("mosi stable at rise", 32'(mosi), 32'(prev_m));
                check("sclk low width", 32'(i - last_fall), 32'(d + 1));
                bits      = {bits[6:0], mosi};
                rises++;
                last_rise = i;
            end else if (prev_s && !sclk) begin
                check("sclk high width", 32'(i - last_rise), 32'(d + 1));
                last_fall = i;
            end
            prev_s = sclk;
            prev_m = mosi;
        end
        check("sclk rise count", 32'(rises), 32'd8);
        check("mosi sequence", 32'(bits), 32'(tx));
    endtask

    initial begin
        logic [7:0] v, st, tx, exp_st;
        logic       cur_cs;
        int         d, inj;

        reset    = 1'b1;
        enable   = 1'b0;
        write_en = 1'b0;
        addr     = '0;
        data_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int o = 0; o < 4; o++) begin
            rd(2'(o), v);
            check($sformatf("reset read off%0d", o), 32'(v), 32'd0);
        end
        check("reset sclk", 32'(sclk), 32'd0);
        check("reset cs_n", 32'(cs_n), 32'd1);
        check("reset mosi", 32'(mosi), 32'd0);
        @(posedge clk);
        #1;

        wr(O_DIV, 8'h02);
        rd(O_DIV, v);
        check("clkdiv readback", 32'(v), 32'h02);
        enable = 1'b0;
        addr   = 8'h02;
        #1;
        check("unselected data_out", 32'(data_out), 32'd0);
        enable = 1'b1;
        addr   = 8'h06;
        #1;
        check("other block data_out", 32'(data_out), 32'd0);
        enable = 1'b0;
        @(posedge clk);
        #1;

        xfer(8'hA5, 2, 0, 8'h00, st);
        check("A5 status", 32'(st), 32'h02);
        rd(O_DATA, v);
        check("A5 rx", 32'(v), 32'hA5);
        @(posedge clk);
        #1;

        xfer(8'h3C, 2, 1, 8'h00, st);
        check("overrun status", 32'(st), 32'h06);
        rd(O_DATA, v);
        check("overrun rx kept", 32'(v), 32'h3C);
        @(posedge clk);
        #1;
        wr(O_CTRL, 8'h06);
        rd(O_CTRL, v);
        check("clear done+ovr", 32'(v), 32'h00);
        @(posedge clk);
        #1;

        wr(O_CTRL, 8'h08);
        check("cs_n asserted", 32'(cs_n), 32'd0);
        wave(0, 8'h81);
        wave(1, 8'($urandom));
        wr(O_CTRL, 8'h06);
        check("cs_n released", 32'(cs_n), 32'd1);

        cur_cs = 1'b0;
        for (int it = 0; it < 10; it++) begin
            d      = $urandom_range(2, 5);
            tx     = 8'($urandom);
            inj    = $urandom_range(0, 3);
            cur_cs = 1'($urandom);
            wr(O_DIV, 8'(d));
            wr(O_CTRL, {4'd0, cur_cs, 3'b110});
            xfer(tx, d, inj, {4'd0, cur_cs, 3'b000}, st);
            exp_st = {4'd0, cur_cs, (inj == 1 || inj == 2), 1'b1, 1'b0};
            check($sformatf("rand%0d status", it), 32'(st), 32'(exp_st));
            rd(O_DATA, v);
            check($sformatf("rand%0d rx", it), 32'(v), 32'(tx));
            check($sformatf("rand%0d cs_n", it), 32'(cs_n), 32'(!cur_cs));
            @(posedge clk);
            #1;
            rd(O_CTRL, v);
            check($sformatf("rand%0d stays idle", it), 32'(v[0]), 32'd0);
        end

`ifdef REFLET_SPI_INTERRUPT_EN
        wr(O_DIV, 8'h02);
        wr(O_CTRL, 8'h16);
        check("irq low before", 32'(irq), 32'd0);
        xfer(8'h55, 2, 0, 8'h10, st);
        check("ie status", 32'(st), 32'h12);
        check("irq with done", 32'(irq), 32'd1);
        @(posedge clk);
        #1;
        wr(O_CTRL, 8'h12);
        check("irq cleared", 32'(irq), 32'd0);
        rd(O_CTRL, v);
        check("ie kept", 32'(v), 32'h10);
        wr(O_CTRL, 8'h00);
`else
        wr(O_CTRL, 8'h16);
        rd(O_CTRL, v);
        check("ie absent", 32'(v), 32'h00);
`endif
        @(posedge clk);
        #1;

        wr(O_DIV, 8'h02);
        wr(O_CTRL, 8'h0E);
        wr(O_DATA, 8'hC3);
        for (int i = 1; i <= 22; i++) begin
            @(posedge clk);
            #1;
        end
        check("sclk high at bit 3", 32'(sclk), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("reset sclk async", 32'(sclk), 32'd0);
        check("reset cs_n async", 32'(cs_n), 32'd1);
        rd(O_CTRL, v);
        check("reset status", 32'(v), 32'h00);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        wr(O_DIV, 8'h02);
        xfer(8'h5A, 2, 0, 8'h00, st);
        check("post-reset status", 32'(st), 32'h02);
        rd(O_DATA, v);
        check("post-reset rx", 32'(v), 32'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
